// File: rtl/alu_exec_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the 8-bit CPU decode/execute stage:
//   - opcode constants (OPC_LOADI .. OPC_OR)
//   - ALU operation selects (ALU_FWD, ALU_ADD, ALU_AND, ALU_OR)
//   - dec_t : decoded control bundle {aluop, imm, sign, we, illegal}
// ---------------------------------------------------------------------------
package alu_exec_pkg;

    localparam logic [7:0] OPC_LOADI = 8'h00;
    localparam logic [7:0] OPC_MOV   = 8'h01;
    localparam logic [7:0] OPC_ADD   = 8'h02;
    localparam logic [7:0] OPC_SUB   = 8'h03;
    localparam logic [7:0] OPC_AND   = 8'h04;
    localparam logic [7:0] OPC_OR    = 8'h05;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef struct packed {
        logic [2:0] aluop;
        logic       imm;
        logic       sign;
        logic       we;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_exec_stage_mux2.sv
// ---------------------------------------------------------------------------
// operand_mux2
// Parameterised DATA_W-wide 2:1 mux used for operand-B selection.
// Ports:
//   SEL  in  1       0 -> IN0, 1 -> IN1
//   IN0  in  DATA_W
//   IN1  in  DATA_W
//   OUT  out DATA_W
// ---------------------------------------------------------------------------
module operand_mux2 #(
    parameter int DATA_W = 8
) (
    input  logic              SEL,
    input  logic [DATA_W-1:0] IN0,
    input  logic [DATA_W-1:0] IN1,
    output logic [DATA_W-1:0] OUT
);

    assign OUT = SEL ? IN1 : IN0;

endmodule

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Combined decode/execute stage of the 8-bit single-cycle CPU. Decodes the
// opcode, selects operand B (register, its negation, or immediate), runs the
// ALU and registers result + write enable for the register-file write port.
// One-cycle latency, one instruction per cycle, no handshake.
//
// Ports:
//   CLK          in   1       clock, rising edge
//   RESET        in   1       synchronous, active-low
//   OPCODE       in   OPC_W   instruction bits [31:24]
//   REGOUT1      in   DATA_W  operand A
//   REGOUT2      in   DATA_W  operand B source
//   IMMEDIATE    in   DATA_W  instruction bits [7:0]
//   ALURESULT    out  DATA_W  registered result
//   WRITEENABLE  out  1       registered write enable
//   ALUOP        out  3       combinational decoded ALU select (debug)
//   ILLEGAL      out  1       registered: last opcode was undefined
//   ZERO         out  1       registered (result == 0), reset value 1;
//                             present only with ALU_EXEC_ZERO_FLAG_EN
//
// Optional macro: ALU_EXEC_ZERO_FLAG_EN adds the ZERO output.
// ---------------------------------------------------------------------------
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [OPC_W-1:0]  OPCODE,
    input  logic [DATA_W-1:0] REGOUT1,
    input  logic [DATA_W-1:0] REGOUT2,
    input  logic [DATA_W-1:0] IMMEDIATE,
    output logic [DATA_W-1:0] ALURESULT,
    output logic              WRITEENABLE,
    output logic [2:0]        ALUOP,
`ifdef ALU_EXEC_ZERO_FLAG_EN
    output logic              ZERO,
`endif
    output logic              ILLEGAL
);

    dec_t              dec;
    logic [DATA_W-1:0] neg;
    logic [DATA_W-1:0] mux_sign;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] alu_res;

    // Decode: undefined opcodes fall through to a forward with no write.
    always_comb begin
        dec = '{aluop: ALU_FWD, imm: 1'b0, sign: 1'b0, we: 1'b0, illegal: 1'b1};
        case (OPCODE)
            OPC_LOADI: dec = '{aluop: ALU_FWD, imm: 1'b1, sign: 1'b0, we: 1'b1, illegal: 1'b0};
            OPC_MOV:   dec = '{aluop: ALU_FWD, imm: 1'b0, sign: 1'b0, we: 1'b1, illegal: 1'b0};
            OPC_ADD:   dec = '{aluop: ALU_ADD, imm: 1'b0, sign: 1'b0, we: 1'b1, illegal: 1'b0};
            OPC_SUB:   dec = '{aluop: ALU_ADD, imm: 1'b0, sign: 1'b1, we: 1'b1, illegal: 1'b0};
            OPC_AND:   dec = '{aluop: ALU_AND, imm: 1'b0, sign: 1'b0, we: 1'b1, illegal: 1'b0};
            OPC_OR:    dec = '{aluop: ALU_OR,  imm: 1'b0, sign: 1'b0, we: 1'b1, illegal: 1'b0};
            default: ;
        endcase
    end

    assign ALUOP = dec.aluop;

    // Two's complement; wraps so that NEG(0)=0 and NEG(0x80)=0x80.
    assign neg = ~REGOUT2 + DATA_W'(1);

    // Sign mux feeds the immediate mux, giving the immediate priority.
    operand_mux2 #(.DATA_W(DATA_W)) u_sign_mux (
        .SEL (dec.sign),
        .IN0 (REGOUT2),
        .IN1 (neg),
        .OUT (mux_sign)
    );

    operand_mux2 #(.DATA_W(DATA_W)) u_imm_mux (
        .SEL (dec.imm),
        .IN0 (mux_sign),
        .IN1 (IMMEDIATE),
        .OUT (b_op)
    );

    always_comb begin
        alu_res = '0;
        case (dec.aluop)
            ALU_FWD: alu_res = b_op;
            ALU_ADD: alu_res = REGOUT1 + b_op;  // carry discarded
            ALU_AND: alu_res = REGOUT1 & b_op;
            ALU_OR:  alu_res = REGOUT1 | b_op;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ALURESULT   <= '0;
            WRITEENABLE <= 1'b0;
            ILLEGAL     <= 1'b0;
        end else begin
            ALURESULT   <= alu_res;
            WRITEENABLE <= dec.we;
            ILLEGAL     <= dec.illegal;
        end
    end

`ifdef ALU_EXEC_ZERO_FLAG_EN
    always_ff @(posedge CLK) begin
        if (!RESET) ZERO <= 1'b1;
        else        ZERO <= (alu_res == '0);
    end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
// Directed bench for alu_exec_stage: reset, loadi/mov, add/sub wrap, logic
// ops, illegal opcode, back-to-back issue and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] OPCODE;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] IMMEDIATE;
    logic [7:0] ALURESULT;
    logic       WRITEENABLE;
    logic [2:0] ALUOP;
    logic       ILLEGAL;
`ifdef ALU_EXEC_ZERO_FLAG_EN
    logic       ZERO;
`endif

    int checks = 0;
    int errors = 0;

    alu_exec_stage #(.DATA_W(8), .OPC_W(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .OPCODE      (OPCODE),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .IMMEDIATE   (IMMEDIATE),
        .ALURESULT   (ALURESULT),
        .WRITEENABLE (WRITEENABLE),
        .ALUOP       (ALUOP),
`ifdef ALU_EXEC_ZERO_FLAG_EN
        .ZERO        (ZERO),
`endif
        .ILLEGAL     (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [7:0] r1,
                         input logic [7:0] r2, input logic [7:0] imm);
        OPCODE = op; REGOUT1 = r1; REGOUT2 = r2; IMMEDIATE = imm;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        drive(8'h02, 8'h11, 8'h22, 8'h00);
        step();
        step();
        checks++;
        if (ALURESULT !== 8'h00 || WRITEENABLE !== 1'b0 || ILLEGAL !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got res=%h we=%b ill=%b, expected 00 0 0",
                     ALURESULT, WRITEENABLE, ILLEGAL);
        end
`ifdef ALU_EXEC_ZERO_FLAG_EN
        checks++;
        if (ZERO !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero: got %b expected 1", ZERO);
        end
`endif
        RESET = 1'b1;
        step();
        checks++;
        if (ALURESULT !== 8'h33 || WRITEENABLE !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_add: got res=%h we=%b expected 33 1",
                     ALURESULT, WRITEENABLE);
        end
    endtask

    task automatic test_loadi_mov();
        drive(8'h00, 8'hAA, 8'h77, 8'h5A);
        step();
        checks++;
        if (ALURESULT !== 8'h5A || WRITEENABLE !== 1'b1) begin
            errors++;
            $display("FAIL loadi: got res=%h we=%b expected 5a 1", ALURESULT, WRITEENABLE);
        end
        drive(8'h01, 8'hAA, 8'h3C, 8'hFF);
        step();
        checks++;
        if (ALURESULT !== 8'h3C || WRITEENABLE !== 1'b1) begin
            errors++;
            $display("FAIL mov: got res=%h we=%b expected 3c 1", ALURESULT, WRITEENABLE);
        end
    endtask

    task automatic test_add_sub();
        logic [7:0] r1 [4] = '{8'hFF, 8'h05, 8'h10, 8'h00};
        logic [7:0] r2 [4] = '{8'h01, 8'h07, 8'h00, 8'h80};
        logic [7:0] op [4] = '{8'h02, 8'h03, 8'h03, 8'h03};
        logic [7:0] ex [4] = '{8'h00, 8'hFE, 8'h10, 8'h80};
        for (int i = 0; i < 4; i++) begin
            drive(op[i], r1[i], r2[i], 8'h99);
            #1;
            checks++;
            if (ALUOP !== 3'b001) begin
                errors++;
                $display("FAIL add_sub_aluop[%0d]: got %b expected 001", i, ALUOP);
            end
            step();
            checks++;
            if (ALURESULT !== ex[i] || WRITEENABLE !== 1'b1) begin
                errors++;
                $display("FAIL add_sub[%0d]: got res=%h we=%b expected %h 1",
                         i, ALURESULT, WRITEENABLE, ex[i]);
            end
        end
    endtask

    task automatic test_logic();
        drive(8'h04, 8'hF0, 8'h3C, 8'h00);
        #1;
        checks++;
        if (ALUOP !== 3'b010) begin
            errors++;
            $display("FAIL and_aluop: got %b expected 010", ALUOP);
        end
        step();
        checks++;
        if (ALURESULT !== 8'h30) begin
            errors++;
            $display("FAIL and: got %h expected 30", ALURESULT);
        end
        drive(8'h05, 8'hF0, 8'h3C, 8'h00);
        #1;
        checks++;
        if (ALUOP !== 3'b011) begin
            errors++;
            $display("FAIL or_aluop: got %b expected 011", ALUOP);
        end
        step();
        checks++;
        if (ALURESULT !== 8'hFC) begin
            errors++;
            $display("FAIL or: got %h expected fc", ALURESULT);
        end
    endtask

    task automatic test_illegal();
        drive(8'h07, 8'h12, 8'h6B, 8'hEE);
        #1;
        checks++;
        if (ALUOP !== 3'b000) begin
            errors++;
            $display("FAIL illegal_aluop: got %b expected 000", ALUOP);
        end
        step();
        checks++;
        if (ALURESULT !== 8'h6B || WRITEENABLE !== 1'b0 || ILLEGAL !== 1'b1) begin
            errors++;
            $display("FAIL illegal: got res=%h we=%b ill=%b expected 6b 0 1",
                     ALURESULT, WRITEENABLE, ILLEGAL);
        end
        drive(8'h02, 8'h01, 8'h02, 8'h00);
        step();
        checks++;
        if (ALURESULT !== 8'h03 || WRITEENABLE !== 1'b1 || ILLEGAL !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: got res=%h we=%b ill=%b expected 03 1 0",
                     ALURESULT, WRITEENABLE, ILLEGAL);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op [3] = '{8'h00, 8'h02, 8'h05};
        logic [7:0] r1 [3] = '{8'h55, 8'hFF, 8'h0F};
        logic [7:0] r2 [3] = '{8'h66, 8'h01, 8'hF0};
        logic [7:0] im [3] = '{8'h01, 8'h77, 8'h77};
        logic [7:0] ex [3] = '{8'h01, 8'h00, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            drive(op[i], r1[i], r2[i], im[i]);
            step();
            checks++;
            if (ALURESULT !== ex[i] || WRITEENABLE !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: got res=%h we=%b expected %h 1",
                         i, ALURESULT, WRITEENABLE, ex[i]);
            end
`ifdef ALU_EXEC_ZERO_FLAG_EN
            checks++;
            if (ZERO !== (i == 1)) begin
                errors++;
                $display("FAIL b2b_zero[%0d]: got %b expected %b", i, ZERO, (i == 1));
            end
`endif
        end
    endtask

    task automatic test_midstream_reset();
        drive(8'h02, 8'h20, 8'h04, 8'h00);
        RESET = 1'b0;
        step();
        checks++;
        if (ALURESULT !== 8'h00 || WRITEENABLE !== 1'b0 || ILLEGAL !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset: got res=%h we=%b ill=%b expected 00 0 0",
                     ALURESULT, WRITEENABLE, ILLEGAL);
        end
        RESET = 1'b1;
        step();
        checks++;
        if (ALURESULT !== 8'h24 || WRITEENABLE !== 1'b1) begin
            errors++;
            $display("FAIL midstream_release: got res=%h we=%b expected 24 1",
                     ALURESULT, WRITEENABLE);
        end
    endtask

    initial begin
        RESET = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 8'h00);
        #2;
        test_reset();
        test_loadi_mov();
        test_add_sub();
        test_logic();
        test_illegal();
        test_back_to_back();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
